// File: rtl/div_unit.sv
// div_unit: sequential restoring divider for div/divu.
// Quotient goes to lo_out, remainder goes to hi_out. Signed operations divide
// magnitudes and then fix the signs: the quotient truncates toward zero and
// the remainder takes the sign of the dividend. A zero divisor skips the
// iterations, raises div_zero and leaves hi_out/lo_out untouched.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_ZERO = 2'd3;

    // Counter value of the final quotient-bit iteration.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    // Absolute value when the operand is treated as signed, raw value otherwise.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        if (sgn && v[WIDTH-1]) begin
            return twos_neg(v);
        end else begin
            return v;
        end
    endfunction

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic [WIDTH-1:0] quo_q,      quo_d;
    logic [WIDTH-1:0] dvs_q,      dvs_d;
    logic             neg_quo_q,  neg_quo_d;
    logic             neg_rem_q,  neg_rem_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;

    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   trial_s;
    logic             trial_ok_s;

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[WIDTH-1]};
        trial_s     = rem_shift_s - {1'b0, dvs_q};
        trial_ok_s  = ~trial_s[WIDTH];
    end

    // Next-state and datapath update for the IDLE/RUN/FIX/ZERO sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    neg_quo_d  = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d  = div_signed & dividend[WIDTH-1];
                    quo_d      = magnitude(dividend, div_signed);
                    dvs_d      = magnitude(divisor, div_signed);
                    rem_d      = {WIDTH{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    div_zero_d = 1'b0;
                    busy_d     = 1'b1;
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d = ST_ZERO;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (trial_ok_s) begin
                    rem_d = trial_s[WIDTH-1:0];
                end else begin
                    // A failed trial implies the shifted remainder's top bit was clear.
                    rem_d = rem_shift_s[WIDTH-1:0];
                end
                quo_d = {quo_q[WIDTH-2:0], trial_ok_s};
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX: begin
                // -2^(WIDTH-1) / -1 lands here with neg_quo clear, so the magnitude passes through.
                if (neg_quo_q) begin
                    lo_d = twos_neg(quo_q);
                end else begin
                    lo_d = quo_q;
                end
                if (neg_rem_q) begin
                    hi_d = twos_neg(rem_q);
                end else begin
                    hi_d = rem_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ZERO: begin
                done_d     = 1'b1;
                div_zero_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            rem_q      <= {WIDTH{1'b0}};
            quo_q      <= {WIDTH{1'b0}};
            dvs_q      <= {WIDTH{1'b0}};
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed vectors, a cycle-level reference model
// built on plain arithmetic, and hand-computed literal expectations.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e0_cyc = 0;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .div_signed(div_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result {remainder, quotient} from plain arithmetic.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'h0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: an accepted start finishes 33 edges later (1 for a zero divisor).
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dz   = 1'b0;
    logic [31:0] m_hi   = 32'h0;
    logic [31:0] m_lo   = 32'h0;
    logic [31:0] p_hi   = 32'h0;
    logic [31:0] p_lo   = 32'h0;
    logic        p_dz   = 1'b0;
    int          m_left = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_hi <= 32'h0; m_lo <= 32'h0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    m_hi <= p_hi; m_lo <= p_lo; m_dz <= p_dz;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_dz   <= 1'b0;
                if (divisor == 32'h0) begin
                    m_left <= 1; p_hi <= m_hi; p_lo <= m_lo; p_dz <= 1'b1;
                end else begin
                    m_left <= 33;
                    {p_hi, p_lo} <= ref_div(div_signed, dividend, divisor);
                    p_dz <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("cyc_busy", {63'h0, busy}, {63'h0, m_busy});
        chk("cyc_done", {63'h0, done}, {63'h0, m_done});
        chk("cyc_div_zero", {63'h0, div_zero}, {63'h0, m_dz});
        chk("cyc_hi_lo", {hi_out, lo_out}, {m_hi, m_lo});
    end

    // Drive a start for one cycle; e0_cyc records the accepting edge.
    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; div_signed = sg; dividend = a; divisor = b;
        @(posedge clk); #1;
        e0_cyc = cyc;
        start = 1'b0;
        div_signed = $urandom_range(0, 1);
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Wait (bounded) for done; return edges elapsed since E0.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - e0_cyc;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got no done expected done within 60 cycles");
        end
    endtask

    task automatic run_op(input string name, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int exp_lat, input logic exp_dz);
        int lat;
        issue(sg, a, b);
        wait_done(lat);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_lo"}, {32'h0, lo_out}, {32'h0, exp_lo});
        chk({name, "_hi"}, {32'h0, hi_out}, {32'h0, exp_hi});
        chk({name, "_dz"}, {63'h0, div_zero}, {63'h0, exp_dz});
    endtask

    initial begin
        int lat;
        int seen;
        reset = 1'b0; start = 1'b0; div_signed = 1'b0; dividend = 32'h0; divisor = 32'h0;

        // Model pins.
        chk("model_100_7",  ref_div(1'b1, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_m7_2",   ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_7_m2",   ref_div(1'b1, 32'd7, 32'hFFFF_FFFE), {32'h1, 32'hFFFF_FFFD});
        chk("model_u_ff_10", ref_div(1'b0, 32'hFFFF_FFFF, 32'h10), {32'hF, 32'h0FFF_FFFF});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, div_zero, 29'h0, hi_out, lo_out}, 96'h0 >> 32);
        reset = 1'b1;

        run_op("s_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        run_op("s_5_0", 1'b1, 32'd5, 32'd0, 32'd14, 32'd2, 1, 1'b1);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 33, 1'b0);
        run_op("u_ff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33, 1'b0);
        run_op("s_ff_10", 1'b1, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'hFFFF_FFFF, 33, 1'b0);

        // Overflow case with a stray start during iteration 5.
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (4) @(posedge clk);
        #1; start = 1'b1; div_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        wait_done(lat);
        chk("ovf_lat", 64'(lat), 64'd33);
        chk("ovf_result", {hi_out, lo_out}, {32'h0, 32'h8000_0000});

        // Reset at iteration 10 aborts the operation.
        issue(1'b1, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        chk("abort_state", {busy, done, 30'h0, hi_out, lo_out}, 96'h0 >> 32);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run_op("u_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
